fp_exec_seq: RTL

Issue/retire sequencer wrapped around the FP ALU in the RV32IF execute stage. Accepts one FP operation at a time over a valid/ready handshake, resolves dynamic rounding against `frm`, drives the ALU with `alu_enable` asserted only while the operation executes, and counts a per-op-class latency. It then captures result and flags into an output register, and accumulates sticky exception flags into the `fflags` field of `fcsr` on retirement.

---
 rtl/fp_pkg.sv | 57 +++++
 rtl/fp_fcsr_regs.sv | 43 ++++
 rtl/fp_exec_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the RV32IF FP execute stage.
//   - 5-bit FP ALU opcodes (FP_ADD = 0 ... FP_LE = 23)
//   - rounding-mode encodings (RNE..RMM, DYN)
//   - fflags bit positions (NV, DZ, OF, UF, NX)
//   - issue/retire sequencer state enum
package fp_pkg;

    localparam logic [4:0] FP_ADD      = 5'd0;
    localparam logic [4:0] FP_SUB      = 5'd1;
    localparam logic [4:0] FP_MUL      = 5'd2;
    localparam logic [4:0] FP_DIV      = 5'd3;
    localparam logic [4:0] FP_SQRT     = 5'd4;
    localparam logic [4:0] FP_MIN      = 5'd5;
    localparam logic [4:0] FP_MAX      = 5'd6;
    localparam logic [4:0] FP_MADD     = 5'd7;
    localparam logic [4:0] FP_MSUB     = 5'd8;
    localparam logic [4:0] FP_NMADD    = 5'd9;
    localparam logic [4:0] FP_NMSUB    = 5'd10;
    localparam logic [4:0] FP_SGNJ     = 5'd11;
    localparam logic [4:0] FP_SGNJN    = 5'd12;
    localparam logic [4:0] FP_SGNJX    = 5'd13;
    localparam logic [4:0] FP_CVT_W_S  = 5'd14;
    localparam logic [4:0] FP_CVT_WU_S = 5'd15;
    localparam logic [4:0] FP_CVT_S_W  = 5'd16;
    localparam logic [4:0] FP_CVT_S_WU = 5'd17;
    localparam logic [4:0] FP_MV_X_W   = 5'd18;
    localparam logic [4:0] FP_MV_W_X   = 5'd19;
    localparam logic [4:0] FP_CLASS    = 5'd20;
    localparam logic [4:0] FP_EQ       = 5'd21;
    localparam logic [4:0] FP_LT       = 5'd22;
    localparam logic [4:0] FP_LE       = 5'd23;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Encodings above RMM are reserved; DYN is only legal before resolution.
    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm > RM_RMM);
    endfunction

endpackage

// File: rtl/fp_fcsr_regs.sv
// fp_fcsr_regs: frm / fflags fields of fcsr.
//   clk, rst_n           : clock, async active-low reset
//   frm_we_i/frm_wdata_i : CSR write of frm
//   ffl_we_i/ffl_wdata_i : CSR write of fflags
//   acc_en_i/acc_flags_i : retire-time OR accumulation of exception flags
//   frm_o, fflags_o      : current field values
// A CSR write and an accumulation in the same cycle combine as wdata | flags.
module fp_fcsr_regs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frm_we_i,
    input  logic [2:0] frm_wdata_i,
    input  logic       ffl_we_i,
    input  logic [4:0] ffl_wdata_i,
    input  logic       acc_en_i,
    input  logic [4:0] acc_flags_i,
    output logic [2:0] frm_o,
    output logic [4:0] fflags_o
);
    logic [2:0] frm_q, frm_d;
    logic [4:0] fflags_q, fflags_d;

    always_comb begin
        frm_d    = frm_q;
        fflags_d = fflags_q;
        if (frm_we_i) frm_d = frm_wdata_i;
        if (ffl_we_i) fflags_d = ffl_wdata_i;
        if (acc_en_i) fflags_d = fflags_d | acc_flags_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q    <= 3'd0;
            fflags_q <= 5'd0;
        end else begin
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

    assign frm_o    = frm_q;
    assign fflags_o = fflags_q;
endmodule

// File: rtl/fp_exec_seq.sv
// fp_exec_seq: issue/retire sequencer around the FP ALU.
//   Issue  : in_valid/in_ready, in_op/in_a/in_b/in_c/in_rm/in_rd/in_int_dst
//   ALU    : alu_a/b/c, alu_ctrl, alu_rm, alu_enable out; alu_result/alu_fflags in
//   Retire : out_valid/out_ready, out_result/out_fflags/out_rd/out_int_dst/out_illegal
//   CSR    : csr_frm_we/wdata, csr_fflags_we/wdata in; frm, fflags out
//   Debug  : dbg_state (current FSM state)
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; flush in the same cycle cancels the transfer and returns to IDLE.
// Optional macro FP_OPERAND_ISOLATION_EN: zero the alu_* operand/control
// outputs outside EXEC.
module fp_exec_seq
    import fp_pkg::*;
#(
    parameter int ARITH_LAT = 1,
    parameter int DIV_LAT   = 10,
    parameter int SQRT_LAT  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic [2:0]  in_rm,
    input  logic [4:0]  in_rd,
    input  logic        in_int_dst,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_c,
    output logic [4:0]  alu_ctrl,
    output logic [2:0]  alu_rm,
    output logic        alu_enable,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_fflags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_fflags,
    output logic [4:0]  out_rd,
    output logic        out_int_dst,
    output logic        out_illegal,
    input  logic        csr_frm_we,
    input  logic [2:0]  csr_frm_wdata,
    input  logic        csr_fflags_we,
    input  logic [4:0]  csr_fflags_wdata,
    output logic [2:0]  frm,
    output logic [4:0]  fflags,
    output logic [1:0]  dbg_state
);
    localparam logic [4:0] ARITH_M1 = 5'(ARITH_LAT - 1);
    localparam logic [4:0] DIV_M1   = 5'(DIV_LAT - 1);
    localparam logic [4:0] SQRT_M1  = 5'(SQRT_LAT - 1);

    seq_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, rd_q, res_flags_q;
    logic [31:0] a_q, b_q, c_q, res_q;
    logic [2:0]  rm_q;
    logic        int_dst_q, illegal_q;

    logic        accept, capture, retire;
    logic [2:0]  rm_res;
    logic        rm_bad;
    logic [4:0]  lat_m1;

    assign rm_res = (in_rm == RM_DYN) ? frm : in_rm;
    assign rm_bad = rm_is_illegal(rm_res);

    always_comb begin
        lat_m1 = ARITH_M1;
        if (in_op == FP_DIV)  lat_m1 = DIV_M1;
        if (in_op == FP_SQRT) lat_m1 = SQRT_M1;
    end

    assign accept  = (state_q == ST_IDLE) && in_valid && !flush;
    assign capture = (state_q == ST_EXEC) && (cnt_q == 5'd0) && !flush;
    assign retire  = (state_q == ST_DONE) && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    state_d = rm_bad ? ST_DONE : ST_EXEC;
                    cnt_d   = rm_bad ? 5'd0 : lat_m1;
                end
                ST_EXEC: begin
                    if (cnt_q == 5'd0) state_d = ST_DONE;
                    else               cnt_d   = cnt_q - 5'd1;
                end
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched op context plus the retire register. An illegal rm skips EXEC,
    // so the result/flags are zeroed at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            c_q         <= 32'd0;
            rm_q        <= 3'd0;
            rd_q        <= 5'd0;
            int_dst_q   <= 1'b0;
            illegal_q   <= 1'b0;
            res_q       <= 32'd0;
            res_flags_q <= 5'd0;
        end else if (accept) begin
            op_q        <= in_op;
            a_q         <= in_a;
            b_q         <= in_b;
            c_q         <= in_c;
            rm_q        <= rm_res;
            rd_q        <= in_rd;
            int_dst_q   <= in_int_dst;
            illegal_q   <= rm_bad;
            res_q       <= 32'd0;
            res_flags_q <= 5'd0;
        end else if (capture) begin
            res_q       <= alu_result;
            res_flags_q <= alu_fflags;
        end
    end

    fp_fcsr_regs u_fcsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .frm_we_i    (csr_frm_we),
        .frm_wdata_i (csr_frm_wdata),
        .ffl_we_i    (csr_fflags_we),
        .ffl_wdata_i (csr_fflags_wdata),
        .acc_en_i    (retire && !illegal_q),
        .acc_flags_i (res_flags_q),
        .frm_o       (frm),
        .fflags_o    (fflags)
    );

`ifdef FP_OPERAND_ISOLATION_EN
    assign alu_a    = (state_q == ST_EXEC) ? a_q  : 32'd0;
    assign alu_b    = (state_q == ST_EXEC) ? b_q  : 32'd0;
    assign alu_c    = (state_q == ST_EXEC) ? c_q  : 32'd0;
    assign alu_ctrl = (state_q == ST_EXEC) ? op_q : 5'd0;
    assign alu_rm   = (state_q == ST_EXEC) ? rm_q : 3'd0;
`else
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_c    = c_q;
    assign alu_ctrl = op_q;
    assign alu_rm   = rm_q;
`endif

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    assign in_ready    = rst_n && (state_q == ST_IDLE);
    assign alu_enable  = (state_q == ST_EXEC);
    assign out_valid   = (state_q == ST_DONE);
    assign out_result  = res_q;
    assign out_fflags  = res_flags_q;
    assign out_rd      = rd_q;
    assign out_int_dst = int_dst_q;
    assign out_illegal = illegal_q;
    assign dbg_state   = state_q;
endmodule
